sort_stream_ctrl: RTL

Stream adapter wrapped around the 8-entry byte selection-sort core. It accepts a frame of 8 bytes on a valid/ready input stream and writes them into the sorter's memory through its `wr/addr/datain` port. It then pulses `start`, waits for the sorter's `ready`, and reads the sorted memory back out through a pipelined read path onto a valid/ready output stream with an end-of-frame marker. It is both the upstream feeder and the downstream consumer of the sorter.

---
 rtl/sort_stream_pkg.sv | 15 +
 rtl/sync_fifo.sv | 64 ++++++
 rtl/sort_stream_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/sort_stream_pkg.sv
// Shared types and constants for the sort stream adapter.
package sort_stream_pkg;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_READ,
    ST_DRAIN
  } sort_stream_state_e;

  localparam int SRT_RD_LAT = 2;
  localparam int FRAME_N    = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head word (first word falls through).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr_reg, rptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [WIDTH-1:0] head_reg;
  logic             do_push, do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = head_reg;
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_reg] <= push_data;
  end

  // head_reg always mirrors mem[rptr_reg]; bypass the array when it is empty
  always_ff @(posedge clk) begin
    if (!nrst) begin
      head_reg <= '0;
    end else if (do_push && (empty || (count_reg == CNT_W'(1) && do_pop))) begin
      head_reg <= push_data;
    end else if (do_pop && count_reg > CNT_W'(1)) begin
      head_reg <= mem[rptr_reg + PTR_W'(1)];
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) wptr_reg <= wptr_reg + PTR_W'(1);
      if (do_pop)  rptr_reg <= rptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/sort_stream_ctrl.sv
// Stream adapter around the byte selection-sort core: loads a frame, sorts, streams it out.
// Define SORT_STREAM_DESC_EN to read the sorted memory back in descending order.
module sort_stream_ctrl
  import sort_stream_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int FIFO_D = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              srt_start,
  output logic              srt_wr,
  output logic [ADDR_W-1:0] srt_addr,
  output logic [DATA_W-1:0] srt_datain,
  input  logic [DATA_W-1:0] srt_dataout,
  input  logic              srt_ready
);

  localparam int N     = 1 << ADDR_W;
  localparam int CNT_W = $clog2(FIFO_D) + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

  sort_stream_state_e    state_reg;
  logic [ADDR_W-1:0]     wcnt_reg, rcnt_reg, ocnt_reg;
  logic                  in_ready_reg, busy_reg, start_reg;
  logic [SRT_RD_LAT-1:0] tag_reg;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic [DATA_W-1:0] fifo_head;
  logic [CNT_W:0]    occupancy;
  logic [ADDR_W-1:0] rd_addr;
  logic              in_fire, rd_issue, drain_done;

  assign in_fire  = in_ready_reg && in_valid;
  assign fifo_pop = !fifo_empty && out_ready;

  // FIFO slots already promised to reads still travelling through the sorter
  always_comb begin
    occupancy = (CNT_W + 1)'(fifo_count);
    for (int i = 0; i < SRT_RD_LAT; i++) begin
      occupancy = occupancy + (CNT_W + 1)'(tag_reg[i]);
    end
  end

  assign rd_issue   = (state_reg == ST_READ) && !fifo_full &&
                      (occupancy < (CNT_W + 1)'(FIFO_D));
  assign fifo_push  = tag_reg[SRT_RD_LAT-1];
  assign drain_done = (tag_reg == '0) &&
                      (fifo_empty || (fifo_count == CNT_W'(1) && fifo_pop));

`ifdef SORT_STREAM_DESC_EN
  assign rd_addr = LAST_IDX - rcnt_reg;
`else
  assign rd_addr = rcnt_reg;
`endif

  always_comb begin
    srt_addr = '0;
    if (in_fire)                    srt_addr = wcnt_reg;
    else if (state_reg == ST_READ)  srt_addr = rd_addr;
  end

  assign srt_wr     = in_fire;
  assign srt_datain = in_fire ? in_data : '0;
  assign srt_start  = start_reg;
  assign in_ready   = in_ready_reg;
  assign busy       = busy_reg;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_reg    <= ST_LOAD;
      wcnt_reg     <= '0;
      rcnt_reg     <= '0;
      in_ready_reg <= 1'b1;
      busy_reg     <= 1'b0;
      start_reg    <= 1'b0;
    end else begin
      start_reg <= 1'b0;
      case (state_reg)
        ST_LOAD: begin
          if (in_fire) begin
            wcnt_reg <= wcnt_reg + ADDR_W'(1);
            if (wcnt_reg == LAST_IDX) begin
              state_reg    <= ST_START;
              in_ready_reg <= 1'b0;
              busy_reg     <= 1'b1;
              start_reg    <= 1'b1;
            end
          end
        end
        ST_START: state_reg <= ST_WAIT;
        // the sorter drops ready on the start edge, so a high here is fresh
        ST_WAIT: if (srt_ready) state_reg <= ST_READ;
        ST_READ: begin
          if (rd_issue) begin
            rcnt_reg <= rcnt_reg + ADDR_W'(1);
            if (rcnt_reg == LAST_IDX) begin
              state_reg <= ST_DRAIN;
              rcnt_reg  <= '0;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state_reg    <= ST_LOAD;
            in_ready_reg <= 1'b1;
            busy_reg     <= 1'b0;
            wcnt_reg     <= '0;
            rcnt_reg     <= '0;
          end
        end
        default: state_reg <= ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) tag_reg <= '0;
    else       tag_reg <= {tag_reg[SRT_RD_LAT-2:0], rd_issue};
  end

  always_ff @(posedge clk) begin
    if (!nrst)         ocnt_reg <= '0;
    else if (fifo_pop) ocnt_reg <= ocnt_reg + ADDR_W'(1);
  end

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_head;
  assign out_last  = !fifo_empty && (ocnt_reg == LAST_IDX);

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_D)
  ) u_out_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .push      (fifo_push),
    .push_data (srt_dataout),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule
